// File: rtl/dm_stage_lsu_pkg.sv
// Shared definitions for the data-memory stage load/store unit.
// Holds the access-size encodings, the LSU state enum and the lane helpers
// that the unit uses to build byte enables and store data.
package common;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // The unused size encoding 3 is handled as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << a;
      SZ_HALF: byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane it could land in,
  // so the byte enables alone select the target lane.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/dm_stage_lsu_load_fmt.sv
// dm_load_fmt: combinational load-data formatter.
// Ports: rdata (raw bus word), addr_lo (byte offset), size, sign_ext in;
// data (lane-selected, sign/zero-extended 32-bit load value) out.
module dm_load_fmt
  import common::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dm_stage_lsu.sv
// dm_stage_lsu: DM-stage load/store unit. Turns an EX/DM load/store into a
// req/ack bus transaction, formats load data, and stalls the upstream pipeline
// (stall_o) until the access completes; non-memory ops pass through to DM/WB.
// Ports: clk/rst_n; EX/DM request fields (dm_re_i, dm_we_i, size_i, sign_ext_i,
// addr_i, wr_data_i, alu_rslt_i, rf_dst_addr_i, rf_we_i); data-memory bus
// (mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_ack_i,
// mem_rdata_i); DM/WB fields (addr_o, mem_data_o, alu_rslt_o, rf_dst_addr_o,
// rf_we_o, dm_re_o); stall_o, misalign_o.
// Optional: define DM_LSU_TIMEOUT_EN to add the bus-ack watchdog and bus_err_o.
module dm_stage_lsu
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] alu_rslt_i,
  input  logic [4:0]  rf_dst_addr_i,
  input  logic        rf_we_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] addr_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_rslt_o,
  output logic [4:0]  rf_dst_addr_o,
  output logic        rf_we_o,
  output logic        dm_re_o,
  output logic        stall_o,
  output logic        misalign_o
`ifdef DM_LSU_TIMEOUT_EN
  ,
  output logic        bus_err_o
`endif
);

  lsu_state_t state_q, state_d;

  logic        is_op, mis, issue;
  logic        to_hit;
  logic        bus_err;
  logic        stall, misalign;

  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic        sign_q, rf_we_q, re_q, we_q;
  logic [4:0]  dst_q;
  logic [31:0] fmt_data;

  assign is_op = dm_re_i | dm_we_i;
  assign mis   = is_misaligned(size_i, addr_i[1:0]);
  assign issue = is_op & ~mis;

`ifdef DM_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // cnt_q holds the number of REQ cycles already completed, so the hit
  // fires during the TIMEOUT_CYCLES-th REQ cycle.
  assign to_hit = (state_q == REQ) && !mem_ack_i &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
      err_q <= to_hit;
    end
  end

  assign bus_err   = err_q;
  assign bus_err_o = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus_err = 1'b0;
`endif

  dm_load_fmt u_load_fmt (
    .rdata    (mem_rdata_i),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    misalign      = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_be_o      = '0;
    mem_wdata_o   = '0;
    addr_o        = addr_i;
    mem_data_o    = '0;
    alu_rslt_o    = alu_rslt_i;
    rf_dst_addr_o = rf_dst_addr_i;
    rf_we_o       = rf_we_i;
    dm_re_o       = dm_re_i;
    case (state_q)
      IDLE: begin
        // Any memory op sends a bubble to DM/WB; the real writeback happens
        // from DONE once the access has completed.
        if (is_op) begin
          rf_we_o = 1'b0;
          dm_re_o = 1'b0;
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
        rf_we_o     = 1'b0;
        dm_re_o     = 1'b0;
        if (mem_ack_i || to_hit) state_d = DONE;
      end
      DONE: begin
        addr_o        = addr_q;
        mem_data_o    = load_q;
        rf_dst_addr_o = dst_q;
        rf_we_o       = rf_we_q & ~bus_err;
        dm_re_o       = re_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While reset is held the frozen upstream op must not keep the pipe stalled.
  assign stall_o    = stall & rst_n;
  assign misalign_o = misalign & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      dst_q   <= '0;
      rf_we_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      if (state_q == IDLE && issue) begin
        addr_q  <= addr_i;
        wdata_q <= store_data(size_i, wr_data_i);
        be_q    <= byte_en(size_i, addr_i[1:0]);
        size_q  <= size_i;
        sign_q  <= sign_ext_i;
        dst_q   <= rf_dst_addr_i;
        rf_we_q <= rf_we_i;
        re_q    <= dm_re_i;
        // A load wins when both strobes are set.
        we_q    <= dm_we_i & ~dm_re_i;
      end
      if (state_q == REQ && mem_ack_i) begin
        load_q <= re_q ? fmt_data : '0;
      end
    end
  end

endmodule

// File: doc/dm_stage_lsu.md
# dm_stage_lsu

Data-memory stage load/store unit of the 32-bit pipeline. It sits between the EX/DM pipeline register and the DM/WB pipeline register. It turns the stage's load/store request into a req/ack transaction on the data-memory bus, formats load data by size and sign, and holds the pipeline with `stall_o` until the access completes. Non-memory instructions pass straight through to DM/WB in the same cycle.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-ack watchdog limit, in cycles. Used only with `DM_LSU_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `dm_re_i` in 1: load request.
- `dm_we_i` in 1: store request.
- `size_i` in 2: access size; `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2.
- `sign_ext_i` in 1: sign-extend load data when 1, zero-extend when 0.
- `addr_i` in 32: byte address (ALU result).
- `wr_data_i` in 32: store data, right-aligned.
- `alu_rslt_i` in 32: ALU result, passed through.
- `rf_dst_addr_i` in 5: destination register.
- `rf_we_i` in 1: register-file write enable.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be_o` out 4: byte enables.
- `mem_wdata_o` out 32: store data replicated into the selected lanes.
- `mem_ack_i` in 1: bus completion; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 32: read data.
- `addr_o` out 32: address to DM/WB.
- `mem_data_o` out 32: formatted load data to DM/WB.
- `alu_rslt_o` out 32: ALU result to DM/WB.
- `rf_dst_addr_o` out 5: destination register to DM/WB.
- `rf_we_o` out 1: register-file write enable to DM/WB.
- `dm_re_o` out 1: load flag to DM/WB.
- `stall_o` out 1: freezes the PC, IF/ID, ID/EX and EX/DM registers.
- `misalign_o` out 1: misaligned access flag.
- `bus_err_o` out 1: watchdog timeout. Exists only with `DM_LSU_TIMEOUT_EN`.

## Operation
- A memory op is `dm_re_i | dm_we_i`. Asserting both is illegal; in that case the load takes priority.
- An access is misaligned when it is a half-word with `addr[0]=1` or a word with `addr[1:0]≠0`.
- A misaligned op is not issued to the bus:
  - `misalign_o=1` for that cycle.
  - `rf_we_o` and `dm_re_o` are forced to 0.
  - `stall_o=0`.
- The FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - An aligned op sets `stall_o=1` combinationally.
  - On the next edge the unit latches the address, write data, byte enables, size, sign, dst, we and re, then moves to REQ.
  - With no op, the stage is a pure passthrough and `mem_data_o=0`.
- REQ:
  - `mem_req_o=1` and `stall_o=1`.
  - The bus outputs are driven from the latched values.
  - When `mem_ack_i=1`, the formatted `mem_rdata_i` is captured into the load register (loads only) and the FSM moves to DONE.
- DONE:
  - `stall_o=0`.
  - The DM/WB outputs come from the latched fields and the load register.
  - The next edge returns the FSM to IDLE unconditionally. The input is then the next instruction, so the same op is never re-issued.
- Byte enables:
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `4'b0011<<{addr[1],1'b0}`.
  - Word: `4'b1111`.
- Write data: byte accesses replicate `wr_data_i[7:0]` ×4; half accesses replicate `wr_data_i[15:0]` ×2.
- Load formatting: select the lane by `addr[1:0]`, then extend to 32 bits by `sign_ext_i`. Examples: byte 0x80 gives 0xFFFFFF80 signed and 0x00000080 unsigned.

## Timing
- Reset values:
  - FSM in IDLE.
  - `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` = 0.
  - Load register = 0.
  - `stall_o`, `misalign_o`, `bus_err_o`, watchdog counter = 0.
  - Passthrough outputs follow the inputs.
- Minimum access latency is 3 cycles: IDLE issue, REQ with ack in the first REQ cycle, then DONE. `stall_o` is high for 2 cycles.
- A wait of k cycles before ack adds k stall cycles.
- `mem_ack_i` is ignored outside REQ.
- Bus outputs are stable for the whole of REQ.
- Reset asserted mid-REQ drops `mem_req_o` immediately and discards the access.

## Configuration
- `DM_LSU_TIMEOUT_EN` defined:
  - An 8-bit counter (width `$clog2(TIMEOUT_CYCLES+1)`) counts REQ cycles.
  - When the count reaches `TIMEOUT_CYCLES` without an ack, the FSM moves to DONE with `bus_err_o=1` for one cycle and `rf_we_o=0`.
  - The counter clears in IDLE.
- `DM_LSU_TIMEOUT_EN` undefined: REQ waits indefinitely, and neither the counter nor `bus_err_o` exists.

## Structure
- Package `common` holds:
  - `SZ_BYTE`, `SZ_HALF`, `SZ_WORD` encodings.
  - The `lsu_state_t` enum {IDLE, REQ, DONE}.
- Sub-module `dm_load_fmt` is combinational. It takes rdata, `addr[1:0]`, size and sign, and returns the formatted 32-bit load data.

## Test plan
- LW from 0x100 with the ack held off 2 cycles and rdata 0xDEADBEEF:
  - `mem_addr_o`=0x100 and `mem_be_o`=4'hF.
  - `stall_o` is high for 4 cycles.
  - `mem_data_o`=0xDEADBEEF in DONE.
  - `rf_we_o`=1.
- Signed LB from 0x103 with rdata 0x80123456 → `mem_be_o`=4'h8, `mem_data_o`=0xFFFFFF80. Unsigned → 0x00000080.
- SH of 0x0000ABCD to 0x202 → `mem_we_o`=1, `mem_be_o`=4'hC, `mem_wdata_o`=0xABCDABCD, `rf_we_o`=0.
- LW to 0x101 → no `mem_req_o`, `misalign_o`=1, `rf_we_o`=0, `stall_o`=0.
- Back-to-back LW 0x10 then ADD: the ADD passes through unstalled in the cycle after DONE, with the `alu_rslt_o` value forwarded.
- Reset pulsed in the 2nd REQ cycle → `mem_req_o`=0 and `stall_o`=0 immediately, FSM in IDLE.
- With `DM_LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4 and no ack → `bus_err_o`=1 one cycle after the 4th REQ cycle, `rf_we_o`=0, then IDLE.
